// File: rtl/sipo_pkg.sv
// Shared definitions for the framed serial-in/parallel-out receiver.
// Contents:
//   state_e  - receiver FSM state (IDLE, SHIFT)
//   SIZE_MIN - smallest supported word width
//   SIZE_MAX - largest supported word width
package sipo_pkg;

  // Supported word-width range for the SIZE parameter
  localparam int unsigned SIZE_MIN = 2;
  localparam int unsigned SIZE_MAX = 64;

  // Receiver state: IDLE between frames, SHIFT while frame_in is asserted
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : sipo_pkg

// File: rtl/sipo_hold.sv
// Output holding register with a valid/ready handshake.
// A completed word is captured when the register is empty or is being
// accepted on the same edge; otherwise the new word is dropped and the
// held word is kept.
// Ports:
//   clk_in - clock
//   rst_in - asynchronous active-high reset
//   load   - a completed word is presented this cycle
//   word   - the completed word
//   ready  - consumer accepts the held word when valid is high
//   data   - held word (registered)
//   valid  - data holds an unconsumed word (registered)
//   drop   - combinational: the presented word is being discarded this cycle
module sipo_hold
  import sipo_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            load,
  input  logic [SIZE-1:0] word,
  input  logic            ready,
  output logic [SIZE-1:0] data,
  output logic            valid,
  output logic            drop
);

  logic [SIZE-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            accept_c;
  logic            take_c;

  // Next-state for the holding register
  always_comb begin
    accept_c = valid_q && ready;
    // Space exists if empty, or the held word leaves on this same edge
    take_c   = load && (!valid_q || ready);
    data_d   = data_q;
    valid_d  = valid_q;
    drop     = load && valid_q && !ready;
    if (take_c) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (accept_c) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule : sipo_hold

// File: rtl/sipo_framed.sv
// Framed serial-in/parallel-out receiver.
// While frame_in is high, each cycle with en_in high samples data_in into
// a shift register. Every SIZE sampled bits form a word that is handed to
// the output holding register with zero extra latency; words stream
// back-to-back inside one frame.
// Optional error flags are built when SIPO_FRAMED_ERR_EN is defined:
// overrun_out (completed word dropped) and abort_out (frame ended mid-word),
// both sticky and cleared by clr_in. Without the macro both read 0 and
// clr_in is ignored.
// Ports:
//   clk_in      - clock, rising edge
//   rst_in      - asynchronous active-high reset
//   en_in       - bit strobe
//   frame_in    - frame active
//   data_in     - serial data
//   data_out    - last completed word
//   valid_out   - data_out holds an unconsumed word
//   ready_in    - consumer accepts data_out
//   overrun_out - sticky: a completed word was dropped
//   abort_out   - sticky: frame ended with a partial word
//   clr_in      - synchronous clear of both sticky flags
module sipo_framed
  import sipo_pkg::*;
#(
  parameter int unsigned SIZE      = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            en_in,
  input  logic            frame_in,
  input  logic            data_in,
  output logic [SIZE-1:0] data_out,
  output logic            valid_out,
  input  logic            ready_in,
  output logic            overrun_out,
  output logic            abort_out,
  input  logic            clr_in
);

  localparam int unsigned CNT_W = $clog2(SIZE);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   sr_q, sr_d;
  logic [SIZE-1:0]   shift_c;
  logic              sample_c;
  logic              last_c;
  logic              load_c;
  logic              abort_set_c;
  logic              hold_drop;

  // Bit sampling, word completion and shift-register next state
  always_comb begin
    sample_c    = (state_q == SHIFT) && frame_in && en_in;
    last_c      = (cnt_q == CNT_W'(SIZE - 1));
    if (MSB_FIRST) begin
      shift_c = {sr_q[SIZE-2:0], data_in};
    end else begin
      shift_c = {data_in, sr_q[SIZE-1:1]};
    end
    load_c      = sample_c && last_c;
    abort_set_c = (state_q == SHIFT) && !frame_in && (cnt_q != '0);
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    if ((state_q != SHIFT) || !frame_in) begin
      // Between frames, or on frame end, any partial word is discarded
      cnt_d = '0;
    end else if (sample_c) begin
      sr_d  = shift_c;
      cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Receiver FSM together with its counter and shift register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      case (state_q)
        IDLE:    if (frame_in)  state_q <= SHIFT;
        SHIFT:   if (!frame_in) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The completed word is the shifted value formed on the final bit
  sipo_hold #(
    .SIZE (SIZE)
  ) u_hold (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (load_c),
    .word   (shift_c),
    .ready  (ready_in),
    .data   (data_out),
    .valid  (valid_out),
    .drop   (hold_drop)
  );

`ifdef SIPO_FRAMED_ERR_EN
  logic overrun_q;
  logic abort_q;

  // Sticky error flags; a set event on the clearing edge wins
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      if (hold_drop)        overrun_q <= 1'b1;
      else if (clr_in)      overrun_q <= 1'b0;
      if (abort_set_c)      abort_q   <= 1'b1;
      else if (clr_in)      abort_q   <= 1'b0;
    end
  end

  assign overrun_out = overrun_q;
  assign abort_out   = abort_q;
`else
  logic unused_err;

  assign overrun_out = 1'b0;
  assign abort_out   = 1'b0;
  assign unused_err  = ^{clr_in, hold_drop, abort_set_c};
`endif

endmodule : sipo_framed

// File: tb/tb_sipo_framed.sv
// Bench for sipo_framed: one MSB-first and one LSB-first instance share
// all inputs. Expected words are queued as the completing bit is driven
// and compared once the clock edge that loads them has passed.
module tb_sipo_framed;

`ifdef SIPO_FRAMED_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic       clk = 1'b0;
  logic       rst, en, frame, din, ready, clr;
  logic [7:0] d_m, d_l;
  logic       v_m, v_l, ov_m, ov_l, ab_m, ab_l;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] m;
    logic [7:0] l;
  } exp_t;

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  sipo_framed #(.SIZE(8), .MSB_FIRST(1'b1)) dut_m (
    .clk_in(clk), .rst_in(rst), .en_in(en), .frame_in(frame), .data_in(din),
    .data_out(d_m), .valid_out(v_m), .ready_in(ready),
    .overrun_out(ov_m), .abort_out(ab_m), .clr_in(clr)
  );

  sipo_framed #(.SIZE(8), .MSB_FIRST(1'b0)) dut_l (
    .clk_in(clk), .rst_in(rst), .en_in(en), .frame_in(frame), .data_in(din),
    .data_out(d_l), .valid_out(v_l), .ready_in(ready),
    .overrun_out(ov_l), .abort_out(ab_l), .clr_in(clr)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_valid(input string tag, input logic exp);
    check({tag, "_valid_m"}, 8'(v_m), 8'(exp));
    check({tag, "_valid_l"}, 8'(v_l), 8'(exp));
  endtask

  task automatic check_flags(input string tag, input logic ov, input logic ab);
    check({tag, "_overrun_m"}, 8'(ov_m), 8'(ov));
    check({tag, "_overrun_l"}, 8'(ov_l), 8'(ov));
    check({tag, "_abort_m"},   8'(ab_m), 8'(ab));
    check({tag, "_abort_l"},   8'(ab_l), 8'(ab));
  endtask

  // One clock: drive at negedge, optionally queue a word, compare after edge
  task automatic tick(input logic f, input logic e, input logic d, input logic r,
                      input logic c, input logic push,
                      input logic [7:0] em, input logic [7:0] el);
    exp_t x;
    @(negedge clk);
    frame = f; en = e; din = d; ready = r; clr = c;
    if (push) begin
      x.m = em;
      x.l = el;
      sb_q.push_back(x);
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("word_m", d_m, x.m);
      check("word_l", d_l, x.l);
      check("load_valid_m", 8'(v_m), 8'd1);
      check("load_valid_l", 8'(v_l), 8'd1);
    end
  endtask

  // Eight bits, first bit = w[7]; optional en_in=0 gap before each bit
  task automatic send(input logic [7:0] w, input logic r, input logic load,
                      input logic [7:0] em, input logic [7:0] el, input logic gaps);
    for (int i = 7; i >= 0; i--) begin
      if (gaps) tick(I, O, ~w[i], r, O, O, 8'h00, 8'h00);
      tick(I, I, w[i], r, O, load && (i == 0), em, el);
    end
  endtask

  task automatic idle(input logic f, input logic r, input logic c);
    tick(f, O, O, r, c, O, 8'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; frame = 1'b0; din = 1'b0; ready = 1'b0; clr = 1'b0;

    vecs[0] = '{word: 8'hB2, exp_m: 8'hB2, exp_l: 8'h4D};
    vecs[1] = '{word: 8'h11, exp_m: 8'h11, exp_l: 8'h88};
    vecs[2] = '{word: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
    vecs[3] = '{word: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
    vecs[4] = '{word: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
    vecs[5] = '{word: 8'h12, exp_m: 8'h12, exp_l: 8'h48};

    #12;
    check("rst_data_m", d_m, 8'h00);
    check("rst_data_l", d_l, 8'h00);
    check_valid("rst", O);
    check_flags("rst", O, O);
    @(negedge clk);
    rst = 1'b0;

    // Single-word frames, consumer always ready: valid lasts one cycle
    foreach (vecs[k]) begin
      idle(I, I, O);
      send(vecs[k].word, I, I, vecs[k].exp_m, vecs[k].exp_l, O);
      idle(O, I, O);
      check_valid("table_after", O);
      check_flags("table", O, O);
    end

    // Two words, consumer stalled: second word dropped
    idle(I, O, O);
    send(8'hA5, O, I, 8'hA5, 8'hA5, O);
    send(8'h3C, O, O, 8'h00, 8'h00, O);
    idle(O, O, O);
    check("ovr_data_m", d_m, 8'hA5);
    check("ovr_data_l", d_l, 8'hA5);
    check_valid("ovr_hold", I);
    check_flags("ovr", ERR, O);
    idle(O, I, O);
    check_valid("ovr_accept", O);
    check_flags("ovr_sticky", ERR, O);
    idle(O, O, I);
    check_flags("ovr_clr", O, O);

    // Frame ends after 5 bits: partial word discarded
    idle(I, I, O);
    for (int i = 0; i < 5; i++) tick(I, I, I, I, O, O, 8'h00, 8'h00);
    idle(O, I, O);
    check_valid("abort", O);
    check_flags("abort", O, ERR);
    idle(I, I, O);
    send(8'h11, I, I, 8'h11, 8'h88, O);
    idle(O, I, O);
    check_flags("abort_sticky", O, ERR);

    // Abort set on the same edge as clear: set wins
    idle(I, I, O);
    for (int i = 0; i < 3; i++) tick(I, I, O, I, O, O, 8'h00, 8'h00);
    idle(O, I, I);
    check_flags("abort_clr_prio", O, ERR);
    idle(O, I, I);
    check_flags("abort_clr", O, O);

    // Accept and completion on the same edge
    idle(I, O, O);
    send(8'h12, O, I, 8'h12, 8'h48, O);
    for (int i = 7; i >= 1; i--) begin
      logic [7:0] w;
      w = 8'h34;
      tick(I, I, w[i], O, O, O, 8'h00, 8'h00);
    end
    check("simul_pre_m", d_m, 8'h12);
    tick(I, I, O, I, O, I, 8'h34, 8'h2C);
    check_flags("simul", O, O);
    idle(O, I, O);
    check_valid("simul_after", O);

    // Back-to-back words in one frame with en_in gaps
    idle(I, I, O);
    send(8'hC5, I, I, 8'hC5, 8'hA3, I);
    send(8'h3A, I, I, 8'h3A, 8'h5C, O);
    idle(O, I, O);
    check_valid("b2b_after", O);
    check_flags("b2b", O, O);

    // Reset mid-frame while a word is held
    idle(I, O, O);
    send(8'h96, O, I, 8'h96, 8'h69, O);
    for (int i = 0; i < 3; i++) tick(I, I, I, O, O, O, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b1; frame = 1'b0; en = 1'b0;
    #1;
    check("rstmid_data_m", d_m, 8'h00);
    check("rstmid_data_l", d_l, 8'h00);
    check_valid("rstmid", O);
    check_flags("rstmid", O, O);
    @(negedge clk);
    rst = 1'b0;
    idle(O, I, O);
    check_valid("rst_release", O);
    check_flags("rst_release", O, O);
    idle(I, I, O);
    send(8'hFF, I, I, 8'hFF, 8'hFF, O);
    idle(O, I, O);
    check_valid("post_rst_after", O);

    check("scoreboard_empty", 8'(sb_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sipo_framed

// File: doc/sipo_framed.md
SIPO_FRAMED -- requirements
Module: sipo_framed

Interface
REQ-001 SHALL have parameter SIZE, default 8, word width in bits; legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 means the first received bit lands in data_out[SIZE-1], 0 means it lands in data_out[0].
REQ-003 SHALL have port clk_in, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en_in, input, 1, bit strobe; data_in is sampled only on cycles where en_in=1 and frame_in=1.
REQ-006 SHALL have port frame_in, input, 1, frame active (chip-select style, active high).
REQ-007 SHALL have port data_in, input, 1, serial data.
REQ-008 SHALL have port data_out, output, SIZE, last completed word.
REQ-009 SHALL have port valid_out, output, 1, data_out holds an unconsumed word.
REQ-010 SHALL have port ready_in, input, 1, consumer accepts the word when valid_out=1 and ready_in=1 on the same edge.
REQ-011 SHALL have port overrun_out, output, 1, sticky flag: a completed word was dropped.
REQ-012 SHALL have port abort_out, output, 1, sticky flag: frame_in fell with a partial word.
REQ-013 SHALL have port clr_in, input, 1, synchronous clear of both sticky flags.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT; IDLE->SHIFT when frame_in=1; SHIFT->IDLE when frame_in=0; frame_in=0 overrides en_in.
REQ-015 SHALL keep a bit counter of width $clog2(SIZE), cleared in IDLE and after each completed word, incremented per sampled bit.
REQ-016 With MSB_FIRST=1, each sampled bit SHALL shift the shift register left with data_in entering bit 0; with MSB_FIRST=0, it SHALL shift right with data_in entering bit SIZE-1.
REQ-017 On the edge sampling the SIZE-th bit, the assembled word SHALL be loaded into data_out and valid_out set, both visible after that edge (zero extra latency); the counter SHALL wrap to 0 and shifting SHALL continue back-to-back within the same frame.
REQ-018 valid_out SHALL clear on an accept edge unless a new word loads on that same edge.
REQ-019 Simultaneous accept and word completion SHALL load the new word, keep valid_out=1, and not flag overrun.
REQ-020 Completion while valid_out=1 and ready_in=0 SHALL drop the new word, retain data_out, and set overrun_out.
REQ-021 frame_in falling with counter non-zero SHALL discard the partial word and set abort_out; falling with counter 0 SHALL not set it.
REQ-022 data_out SHALL change only on a word load; it SHALL NOT follow the shift register.
REQ-023 clr_in=1 SHALL clear both flags; a set event on the same edge SHALL take priority (flag stays 1).

Reset
REQ-024 rst_in=1 SHALL immediately force: state IDLE, counter 0, shift register 0, data_out 0, valid_out 0, overrun_out 0, abort_out 0.
REQ-025 Reset mid-frame SHALL discard the partial word without setting abort_out; after release a new frame SHALL start only on frame_in=1 sampled in IDLE.

Configuration
REQ-026 Macro SIPO_FRAMED_ERR_EN defined: overrun_out and abort_out SHALL behave per REQ-020/021/023.
REQ-027 Macro SIPO_FRAMED_ERR_EN undefined: overrun_out and abort_out SHALL be tied 0, flag logic SHALL be absent, clr_in SHALL be ignored, and the data path SHALL be unchanged.

Structure
REQ-028 Package sipo_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the SIZE range limit constants.
REQ-029 The output holding register with its valid/ready logic SHALL be a sub-module named sipo_hold (ports: load, word, ready, data, valid, drop).

Verification
REQ-030 SIZE=8, MSB_FIRST=1, frame with bits 1,0,1,1,0,0,1,0, ready_in=1 -> data_out=8'hB2 and valid_out=1 for one cycle after the 8th bit.
REQ-031 Same bits, MSB_FIRST=0 -> data_out=8'h4D.
REQ-032 Two back-to-back words 8'hA5 then 8'h3C in one frame, ready_in=0 throughout -> data_out stays 8'hA5, overrun_out=1.
REQ-033 frame_in dropped after 5 bits -> valid_out stays 0, abort_out=1; the next full frame 8'h11 -> data_out=8'h11.
REQ-034 Accept and completion on the same edge -> valid_out stays 1, data_out takes the new word, overrun_out=0.
REQ-035 rst_in pulsed after 3 bits -> all outputs 0 immediately; next frame 8'hFF -> data_out=8'hFF.
